// File: rtl/layer_compositor.sv
// Two-stage sprite/background compositor with colour-key transparency
// and per-layer frame-timed hit-flash, running on the VGA pixel clock.
module layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W = 4,
    parameter bit KEY_EN = 1'b1,
    parameter logic [3*COLOR_W-1:0] KEY_COLOR = 12'hF0F,
    parameter int FLASH_FRAMES = 8,
    parameter logic [3*COLOR_W-1:0] FLASH_COLOR = 12'hFFF
) (
    input  logic                            vga_clk,
    input  logic                            reset_n,
    input  logic                            blank,
    input  logic                            frame_tick,
    input  logic [NUM_LAYERS-1:0]           layer_on,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
    input  logic [3*COLOR_W-1:0]            bg_rgb,
    input  logic [NUM_LAYERS-1:0]           flash_trig,
    output logic [COLOR_W-1:0]              Red,
    output logic [COLOR_W-1:0]              Green,
    output logic [COLOR_W-1:0]              Blue,
    output logic [$clog2(NUM_LAYERS):0]     top_layer,
    output logic [NUM_LAYERS-1:0]           flash_active
);

    localparam int PW = 3 * COLOR_W;
    localparam int IW = $clog2(NUM_LAYERS) + 1;
    localparam int CW = $clog2(FLASH_FRAMES + 1);
    localparam logic [IW-1:0] BG_IDX = IW'(NUM_LAYERS);

    logic [CW-1:0] flash_cnt [NUM_LAYERS];

    logic [NUM_LAYERS-1:0] opaque;
    logic [IW-1:0]         win_idx;
    logic [PW-1:0]         win_rgb;

    logic [IW-1:0] idx_s1;
    logic [PW-1:0] rgb_s1;
    logic [PW-1:0] bg_s1;
    logic          blank_s1;

    logic          flash_hit;
    logic [PW-1:0] pix;

    // Scan from the lowest priority upward so the lowest opaque index wins.
    always_comb begin
        win_idx = BG_IDX;
        win_rgb = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            opaque[i] = layer_on[i] &
                ~(KEY_EN && (layer_rgb[i*PW +: PW] == KEY_COLOR));
            if (opaque[i]) begin
                win_idx = IW'(i);
                win_rgb = layer_rgb[i*PW +: PW];
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_s1   <= BG_IDX;
            rgb_s1   <= '0;
            bg_s1    <= '0;
            blank_s1 <= 1'b0;
        end else begin
            idx_s1   <= win_idx;
            rgb_s1   <= win_rgb;
            bg_s1    <= bg_rgb;
            blank_s1 <= blank;
        end
    end

    // An odd remaining count implies nonzero, so bit 0 alone selects flash.
    always_comb begin
        flash_hit = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (idx_s1 == IW'(i) && flash_cnt[i][0]) flash_hit = 1'b1;
        end
        if (!blank_s1)          pix = '0;
        else if (flash_hit)     pix = FLASH_COLOR;
        else if (idx_s1 == BG_IDX) pix = bg_s1;
        else                    pix = rgb_s1;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            top_layer <= BG_IDX;
        end else begin
            {Red, Green, Blue} <= pix;
            top_layer          <= idx_s1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LAYERS; i++) flash_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (flash_trig[i])
                    flash_cnt[i] <= CW'(FLASH_FRAMES);
                else if (frame_tick && flash_cnt[i] != '0)
                    flash_cnt[i] <= flash_cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++)
            flash_active[i] = (flash_cnt[i] != '0);
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: vector table for the compositing
// path plus hand sequences for flash timing and asynchronous reset.
module tb_layer_compositor;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        blank;
    logic        frame_tick;
    logic [3:0]  layer_on;
    logic [47:0] layer_rgb;
    logic [11:0] bg_rgb;
    logic [3:0]  flash_trig;
    logic [3:0]  Red, Green, Blue;
    logic [2:0]  top_layer;
    logic [3:0]  flash_active;

    int tests = 0;
    int fails = 0;
    int m_cnt [4];

    always #5 vga_clk = ~vga_clk;

    layer_compositor dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .blank(blank),
        .frame_tick(frame_tick), .layer_on(layer_on),
        .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
        .flash_trig(flash_trig), .Red(Red), .Green(Green),
        .Blue(Blue), .top_layer(top_layer),
        .flash_active(flash_active)
    );

    typedef struct {
        string       name;
        logic        blank;
        logic [3:0]  on;
        logic [47:0] lrgb;
        logic [11:0] bg;
        logic [11:0] exp_rgb;
        logic [2:0]  exp_top;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_pix(input logic b, input logic [3:0] on,
                           input logic [47:0] lrgb, input logic [11:0] bg);
        blank = b; layer_on = on; layer_rgb = lrgb; bg_rgb = bg;
    endtask

    // Called at a negedge; lets the held pixel flow through both stages.
    task automatic check_pix(input string name, input logic [11:0] col,
                             input int win);
        logic [11:0] exp;
        @(posedge vga_clk); @(posedge vga_clk); @(negedge vga_clk);
        exp = col;
        if (win < 4 && m_cnt[win] % 2 == 1) exp = 12'hFFF;
        check({name, "_rgb"}, {Red, Green, Blue}, exp);
        check({name, "_top"}, top_layer, win);
    endtask

    // One cycle of frame_tick and/or flash_trig, with the counter model.
    task automatic step(input logic ft, input logic [3:0] trig,
                        input string name);
        frame_tick = ft; flash_trig = trig;
        @(posedge vga_clk);
        for (int i = 0; i < 4; i++) begin
            if (trig[i]) m_cnt[i] = 8;
            else if (ft && m_cnt[i] != 0) m_cnt[i]--;
        end
        @(negedge vga_clk);
        frame_tick = 1'b0; flash_trig = '0;
        check({name, "_active"}, flash_active,
              {m_cnt[3] != 0, m_cnt[2] != 0, m_cnt[1] != 0, m_cnt[0] != 0});
    endtask

    initial begin
        // layer_rgb = {L3, L2, L1, L0}
        vt[0] = '{"bg_only", 1, 4'b0000, 48'h000_000_000_000,
                  12'h123, 12'h123, 3'd4};
        vt[1] = '{"l1_over_l2", 1, 4'b0110, 48'h000_0B0_A00_000,
                  12'h123, 12'hA00, 3'd1};
        vt[2] = '{"l1_keyed", 1, 4'b0110, 48'h000_0B0_F0F_000,
                  12'h123, 12'h0B0, 3'd2};
        vt[3] = '{"blanked", 0, 4'b0110, 48'h000_0B0_A00_000,
                  12'h123, 12'h000, 3'd1};
        vt[4] = '{"all_keyed", 1, 4'b1111, 48'hF0F_F0F_F0F_F0F,
                  12'h456, 12'h456, 3'd4};
        vt[5] = '{"l0_wins", 1, 4'b1111, 48'h111_222_333_00C,
                  12'h456, 12'h00C, 3'd0};
        vt[6] = '{"l3_near_key", 1, 4'b1000, 48'hF0E_222_333_444,
                  12'h456, 12'hF0E, 3'd3};
        vt[7] = '{"none_on", 1, 4'b0000, 48'h111_222_333_444,
                  12'h789, 12'h789, 3'd4};
        vt[8] = '{"fall_to_l3", 1, 4'b1010, 48'h321_222_F0F_444,
                  12'h789, 12'h321, 3'd3};
        vt[9] = '{"blank_bg", 0, 4'b0000, 48'h0,
                  12'h789, 12'h000, 3'd4};
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;

        reset_n = 1'b0; frame_tick = 1'b0; flash_trig = '0;
        set_pix(1, 4'b0000, 48'h0, 12'h123);
        repeat (3) @(negedge vga_clk);
        check("rst_rgb", {Red, Green, Blue}, 12'h000);
        check("rst_top", top_layer, 3'd4);
        check("rst_active", flash_active, 4'b0000);
        reset_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            set_pix(vt[v].blank, vt[v].on, vt[v].lrgb, vt[v].bg);
            @(posedge vga_clk); @(posedge vga_clk); @(negedge vga_clk);
            check({vt[v].name, "_rgb"}, {Red, Green, Blue}, vt[v].exp_rgb);
            check({vt[v].name, "_top"}, top_layer, vt[v].exp_top);
        end

        // Layer 1 flash across eight frames
        set_pix(1, 4'b0010, 48'h000_000_A00_000, 12'h123);
        step(0, 4'b0010, "l1_trig");
        check_pix("l1_cnt8", 12'hA00, 1);
        for (int k = 1; k <= 8; k++) begin
            step(1, 4'b0000, $sformatf("l1_tick%0d", k));
            check_pix($sformatf("l1_frame%0d", k), 12'hA00, 1);
        end

        // Layer 0: load beats a simultaneous tick, retrigger, floor at 0
        set_pix(1, 4'b0001, 48'h000_000_000_00C, 12'h123);
        step(0, 4'b0001, "l0_trig");
        repeat (5) step(1, 4'b0000, "l0_dec");
        check_pix("l0_cnt3", 12'h00C, 0);
        step(1, 4'b0001, "l0_trig_tick");
        check_pix("l0_load_wins", 12'h00C, 0);
        repeat (6) step(1, 4'b0000, "l0_dec2");
        step(0, 4'b0001, "l0_retrig");
        check_pix("l0_retrig8", 12'h00C, 0);
        step(1, 4'b0000, "l0_to7");
        check_pix("l0_cnt7", 12'h00C, 0);
        repeat (7) step(1, 4'b0000, "l0_drain");
        step(1, 4'b0000, "l0_tick_at0");
        check_pix("l0_floor", 12'h00C, 0);

        // Asynchronous reset mid-flash, between clock edges
        set_pix(1, 4'b0100, 48'h000_0B0_000_000, 12'h123);
        step(0, 4'b0100, "l2_trig");
        repeat (3) step(1, 4'b0000, "l2_dec");
        check_pix("l2_cnt5", 12'h0B0, 2);
        #2 reset_n = 1'b0;
        #1;
        check("async_rgb", {Red, Green, Blue}, 12'h000);
        check("async_top", top_layer, 3'd4);
        check("async_active", flash_active, 4'b0000);
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        @(negedge vga_clk);
        reset_n = 1'b1;
        check_pix("post_reset", 12'h0B0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined pixel compositor. Replaces the fixed-priority health/fighter/background mux in the top-level display path.
- Merges NUM_LAYERS sprite layers over a background using a per-pixel priority select and a colour-key transparency.
- Adds per-layer hit-flash effects, timed in frames.
- Sits between the sprite/background ROM readers and the VGA DAC outputs, on vga_clk.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 has highest priority.
- COLOR_W, 4, bits per colour channel.
- KEY_EN, 1, 1 = a layer pixel equal to KEY_COLOR is treated as transparent.
- KEY_COLOR, 12'hF0F, transparent key {R,G,B}; width 3*COLOR_W.
- FLASH_FRAMES, 8, number of frames a hit-flash lasts; must be ≥1.
- FLASH_COLOR, 12'hFFF, colour substituted for a flashing layer's opaque pixels.

Ports:
- vga_clk  in  1  pixel clock; all state is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- blank  in  1  1 = active video (VGA controller convention); 0 forces black output.
- frame_tick  in  1  one-cycle pulse, once per frame, at start of vertical blank.
- layer_on  in  NUM_LAYERS  bit i = layer i covers the current pixel.
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  layer i colour at bits [i*3*COLOR_W +: 3*COLOR_W], ordered {R,G,B}.
- bg_rgb  in  3*COLOR_W  background colour {R,G,B}.
- flash_trig  in  NUM_LAYERS  one-cycle pulse per layer; starts or restarts that layer's flash.
- Red, Green, Blue  out  COLOR_W each  composited pixel, registered.
- top_layer  out  clog2(NUM_LAYERS)+1  index of the winning layer; value NUM_LAYERS = background. Registered, aligned with RGB.
- flash_active  out  NUM_LAYERS  bit i = layer i flash counter nonzero.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Red/Green/Blue = 0.
  - top_layer = NUM_LAYERS.
  - All flash counters = 0, so flash_active = 0.
  - Both pipeline stages clear.
  - Reset mid-frame or mid-flash cancels all effects immediately.
- Input alignment: all pixel-rate inputs (blank, layer_on, layer_rgb, bg_rgb) are sampled together on the same edge. Upstream readers must align them to each other.
- Pipeline, 2 cycles: pixel inputs at edge N produce RGB/top_layer valid after edge N+2.
- Stage 1:
  - Per layer: opaque_i = layer_on[i] & ~(KEY_EN & layer_rgb_i == KEY_COLOR).
  - Priority-encode the opaque bits; the lowest index wins.
  - Register: winning index (NUM_LAYERS if none opaque), winning colour, bg_rgb, blank.
- Stage 2:
  - blank_s1 = 0: RGB = 0; top_layer still reports the registered index.
  - Otherwise, if the winner is layer w, flash_cnt[w] ≠ 0 and flash_cnt[w][0] = 1: RGB = FLASH_COLOR. The layer blinks on odd remaining counts.
  - Otherwise: RGB = the winning colour, or bg_rgb when the winner is the background.
- Flash counter, one per layer, width clog2(FLASH_FRAMES+1):
  - flash_trig[i] = 1: load FLASH_FRAMES. Retrigger while active reloads.
  - Else if frame_tick = 1 and the counter ≠ 0: decrement by 1.
  - Trig and frame_tick in the same cycle: load wins; no decrement that cycle.
  - Saturates at 0; no wrap below 0.
- flash_active[i] = (flash_cnt[i] ≠ 0). It is driven directly from the counter register, with no pipeline delay.
- The flash state used by stage 2 is the counter value at that edge. A counter change takes effect on the next pixel emerging from stage 2 (mid-line change is allowed; frame_tick occurs in blanking, so no visible tear).
- Transparent-pixel fall-through: when a higher layer is on but keyed transparent, the next opaque lower layer, or the background, shows through.
- Widths: all compares are full 3*COLOR_W. top_layer is wide enough to hold NUM_LAYERS.

Test Plan:
- Reset hold, then release with blank=1, layer_on=0, bg_rgb=12'h123 → RGB=0 during reset; from edge 2 after release, RGB=1/2/3 and top_layer=4.
- layer_on=4'b0110, layer1=12'hA00, layer2=12'h0B0 → after 2 cycles RGB=A/0/0 and top_layer=1. Then set layer1=12'hF0F (key colour) → RGB=0/B/0 and top_layer=2.
- Same pixel with blank=0 → RGB=0/0/0 and top_layer=1. Confirms blank overrides the colour but not the index.
- flash_trig[1] pulse, layer1 winning, then 8 frame_ticks → flash_active[1]=1 for 8 frames. RGB is FFF on frames with odd count (8→7 first flash frame) and A00 on even ones; flash_active[1]=0 after the 8th tick.
- flash_trig[0] and frame_tick in the same cycle while cnt=3 → cnt=8, not 7. Retrigger at cnt=2 → cnt=8. frame_tick at cnt=0 → stays 0.
- Assert reset_n low while flash_cnt[2]=5 mid-line → flash_active=0 and RGB=0 asynchronously, without waiting for a clock edge.
